// File: rtl/miriscv_data_ram.sv
// Data-memory responder for the core's req/gnt/rvalid protocol: word RAM with byte enables and a fixed response latency.
// Optional out-of-range error responses are compiled in with `define MIRISCV_DRAM_ERR_EN.
module miriscv_data_ram #(
    parameter int unsigned RAM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [3:0]  CNT_LOAD  = 4'(RESP_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_reg;
    logic [3:0]        cnt_reg;
    logic              we_reg;
    logic              in_range_reg;
    logic [31:0]       rd_word_reg;
    logic [31:0]       hold_rdata_reg;

    logic [31:0]       offset;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [3:0]        wmask;
    logic              unused_bits;

    logic [31:0] mem [RAM_WORDS];

    assign offset      = data_addr_i - BASE_ADDR;
    assign idx         = offset[IDX_W+1:2];
    assign unused_bits = ^{offset[1:0], offset[31:IDX_W+2]};

`ifdef MIRISCV_DRAM_ERR_EN
    assign in_range = (offset < RAM_BYTES);
`else
    // Without the range check the offset simply wraps inside the array.
    assign in_range = 1'b1;
`endif

    assign resp_ready    = (state_reg == BUSY) && (cnt_reg == 4'd0);
    assign data_gnt_o    = !arstn_i && data_req_i && ((state_reg == IDLE) || resp_ready);
    assign data_rvalid_o = resp_ready;
    assign resp_rdata    = (we_reg || !in_range_reg) ? 32'h0 : rd_word_reg;
    assign data_rdata_o  = resp_ready ? resp_rdata : hold_rdata_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi] = data_gnt_o && data_we_i && in_range && data_be_i[gi];
        end
    endgenerate

    // RAM array: write and read both happen at the grant edge, so a later
    // back-to-back read always observes an earlier write.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) begin
                mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
        end
        if (data_gnt_o && !data_we_i) begin
            rd_word_reg <= mem[idx];
        end
    end

    always_ff @(posedge clk_i or posedge arstn_i) begin
        if (arstn_i) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            we_reg         <= 1'b0;
            in_range_reg   <= 1'b0;
            hold_rdata_reg <= 32'h0;
        end else begin
            if (resp_ready) begin
                hold_rdata_reg <= resp_rdata;
            end
            if (data_gnt_o) begin
                we_reg       <= data_we_i;
                in_range_reg <= in_range;
                cnt_reg      <= CNT_LOAD;
                state_reg    <= BUSY;
            end else if (state_reg == BUSY) begin
                if (cnt_reg != 4'd0) begin
                    cnt_reg <= cnt_reg - 4'd1;
                end else begin
                    state_reg <= IDLE;
                end
            end
        end
    end

`ifdef MIRISCV_DRAM_ERR_EN
    logic hold_err_reg;

    always_ff @(posedge clk_i or posedge arstn_i) begin
        if (arstn_i) begin
            hold_err_reg <= 1'b0;
        end else if (resp_ready) begin
            hold_err_reg <= !in_range_reg;
        end
    end

    assign data_err_o = resp_ready ? !in_range_reg : hold_err_reg;
`else
    assign data_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_miriscv_data_ram.sv
// Directed bench for miriscv_data_ram: three instances at latencies 1, 3 and 4 sharing request fields.
module tb_miriscv_data_ram;

    logic        clk;
    logic        rst;
    logic        req1, req3, req4;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;

    logic        gnt1, gnt3, gnt4;
    logic        rvalid1, rvalid3, rvalid4;
    logic [31:0] rdata1, rdata3, rdata4;
    logic        err1, err3, err4;

    int tests = 0;
    int fails = 0;

    miriscv_data_ram u1 (
        .clk_i(clk), .arstn_i(rst), .data_req_i(req1), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt1), .data_rvalid_o(rvalid1),
        .data_rdata_o(rdata1), .data_err_o(err1)
    );

    miriscv_data_ram #(.RAM_WORDS(16), .BASE_ADDR(32'h8000_0000), .RESP_LATENCY(3)) u3 (
        .clk_i(clk), .arstn_i(rst), .data_req_i(req3), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
        .data_rdata_o(rdata3), .data_err_o(err3)
    );

    miriscv_data_ram #(.RESP_LATENCY(4)) u4 (
        .clk_i(clk), .arstn_i(rst), .data_req_i(req4), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt4), .data_rvalid_o(rvalid4),
        .data_rdata_o(rdata4), .data_err_o(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on the latency-1 instance.
    task automatic xact1(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output logic [31:0] rd, output logic er);
        we = w; addr = a; wdata = d; be = b; req1 = 1'b1;
        #4;
        chk("x1_gnt", {31'b0, gnt1}, 32'd1);
        chk("x1_rv_pre", {31'b0, rvalid1}, 32'd0);
        tick();
        req1 = 1'b0;
        #4;
        chk("x1_rvalid", {31'b0, rvalid1}, 32'd1);
        rd = rdata1;
        er = err1;
        tick();
        $display("[TB] u1 %s addr=%h wdata=%h be=%b -> rdata=%h err=%b",
                 w ? "WR" : "RD", a, d, b, rd, er);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] exp3 [5];
    logic        we3  [5];
    logic [31:0] adr3 [5];
    logic [31:0] wd3  [5];

    initial begin
        rst = 1'b1; req1 = 1'b1; req3 = 1'b0; req4 = 1'b0;
        we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        tick();
        tick();
        #4;
        chk("rst_gnt", {31'b0, gnt1}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid1}, 32'd0);
        chk("rst_rdata", rdata1, 32'h0);
        chk("rst_err", {31'b0, err1}, 32'd0);
        tick();
        req1 = 1'b0;
        rst  = 1'b0;
        tick();

        // Basic write then read.
        xact1(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
        chk("wr_rdata_zero", rd, 32'h0);
        xact1(1'b0, 32'h10, 32'h0, 4'hF, rd, er);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);
        chk("rd_err0", {31'b0, er}, 32'd0);

        // Byte enables.
        xact1(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er);
        xact1(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er);
        xact1(1'b0, 32'h20, 32'h0, 4'hF, rd, er);
        chk("be_0101", rd, 32'h11BB33DD);
        xact1(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er);
        xact1(1'b0, 32'h20, 32'h0, 4'hF, rd, er);
        chk("be_0000", rd, 32'h11BB33DD);

        // Back-to-back write then reads, one transaction per cycle.
        we = 1'b1; addr = 32'h40; wdata = 32'h5; be = 4'hF; req1 = 1'b1;
        #4;
        chk("b2b_gnt0", {31'b0, gnt1}, 32'd1);
        chk("b2b_rv0", {31'b0, rvalid1}, 32'd0);
        tick();
        we = 1'b0;
        #4;
        chk("b2b_rv1", {31'b0, rvalid1}, 32'd1);
        chk("b2b_gnt1", {31'b0, gnt1}, 32'd1);
        chk("b2b_wr_rdata", rdata1, 32'h0);
        tick();
        #4;
        chk("b2b_rv2", {31'b0, rvalid1}, 32'd1);
        chk("b2b_gnt2", {31'b0, gnt1}, 32'd1);
        chk("b2b_rd1", rdata1, 32'h5);
        tick();
        req1 = 1'b0;
        #4;
        chk("b2b_rv3", {31'b0, rvalid1}, 32'd1);
        chk("b2b_rd2", rdata1, 32'h5);
        tick();
        #4;
        chk("b2b_rv4", {31'b0, rvalid1}, 32'd0);
        tick();
        $display("[TB] u1 back-to-back WR 40=5, RD 40, RD 40 done");

        // Out-of-range access (wraps onto word 0 without the error option).
        xact1(1'b1, 32'h0, 32'h12345678, 4'hF, rd, er);
        xact1(1'b0, 32'h1000, 32'h0, 4'hF, rd, er);
`ifdef MIRISCV_DRAM_ERR_EN
        chk("oor_rdata", rd, 32'h0);
        chk("oor_err", {31'b0, er}, 32'd1);
`else
        chk("wrap_rdata", rd, 32'h12345678);
        chk("wrap_err", {31'b0, er}, 32'd0);
`endif
        xact1(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er);
        xact1(1'b0, 32'h0, 32'h0, 4'hF, rd, er);
`ifdef MIRISCV_DRAM_ERR_EN
        chk("oor_wr_suppressed", rd, 32'h12345678);
`else
        chk("wrap_wr_word0", rd, 32'hFFFFFFFF);
`endif
        chk("inrange_err0", {31'b0, er}, 32'd0);

        // Latency 3 with request held high; non-zero base address.
        we3  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        adr3 = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 32'h8000_0000};
        wd3  = '{32'h1111, 32'h2222, 32'h0, 32'h0, 32'h0};
        exp3 = '{32'h0, 32'h0, 32'h1111, 32'h2222, 32'h1111};
        for (int k = 0; k <= 15; k++) begin
            int t;
            t = (k + 2) / 3;
            if (t > 4) t = 4;
            we = we3[t]; addr = adr3[t]; wdata = wd3[t]; be = 4'hF;
            req3 = (k <= 12);
            #4;
            chk("l3_gnt", {31'b0, gnt3}, {31'b0, (k % 3 == 0) && (k <= 12)});
            chk("l3_rvalid", {31'b0, rvalid3}, {31'b0, (k % 3 == 0) && (k >= 3)});
            if ((k % 3 == 0) && (k >= 3)) begin
                chk("l3_rdata", rdata3, exp3[k / 3 - 1]);
                chk("l3_err", {31'b0, err3}, 32'd0);
                $display("[TB] u3 response %0d at cycle %0d rdata=%h", k / 3 - 1, k, rdata3);
            end
            tick();
        end
        req3 = 1'b0;

        // Latency 4: write, then reset right after a read grant.
        we = 1'b1; addr = 32'h8; wdata = 32'hCAFE0001; be = 4'hF; req4 = 1'b1;
        #4;
        chk("l4_wr_gnt", {31'b0, gnt4}, 32'd1);
        tick();
        req4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #4;
            chk("l4_wr_rvalid", {31'b0, rvalid4}, {31'b0, i == 4});
            tick();
        end
        $display("[TB] u4 WR 8=CAFE0001 done");
        we = 1'b0; req4 = 1'b1;
        #4;
        chk("l4_rd_gnt", {31'b0, gnt4}, 32'd1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #4;
            chk("l4_rst_gnt", {31'b0, gnt4}, 32'd0);
            chk("l4_rst_rvalid", {31'b0, rvalid4}, 32'd0);
            chk("l4_rst_rdata", rdata4, 32'h0);
            tick();
        end
        rst = 1'b0; req4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #4;
            chk("l4_no_stale_rvalid", {31'b0, rvalid4}, 32'd0);
            tick();
        end
        $display("[TB] u4 RD 8 aborted by reset");
        req4 = 1'b1;
        #4;
        chk("l4_post_gnt", {31'b0, gnt4}, 32'd1);
        tick();
        req4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #4;
            chk("l4_post_rvalid", {31'b0, rvalid4}, {31'b0, i == 4});
            if (i == 4) begin
                chk("l4_post_rdata", rdata4, 32'hCAFE0001);
                chk("l4_post_err", {31'b0, err4}, 32'd0);
            end
            tick();
        end
        $display("[TB] u4 RD 8 after reset -> rdata=%h", rdata4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/miriscv_data_ram.md
Name: miriscv_data_ram

Overview:
- Responder end of the core's data-memory request/grant/rvalid protocol; synchronous word-organised RAM with byte-enable writes.
- Accepts one request at a time and returns the response a programmable number of cycles after the grant.
- Sits between the LSU's data_* outputs and its data_gnt/data_rvalid/data_rdata inputs.
- Used in the SoC top and as the memory model in core benches.

Parameters:
- RAM_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to RAM_WORDS*4.
- RESP_LATENCY, 1: cycles from the grant edge to the rvalid cycle; legal range 1..15.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  reset; one clock; reset is asynchronous and active-high
- data_req_i  in  1  request present
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables; bit n covers wdata[8n+7:8n]
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  request accepted this cycle
- data_rvalid_o  out  1  one-cycle response strobe
- data_rdata_o  out  32  read data, valid while rvalid=1
- data_err_o  out  1  error response, valid while rvalid=1

Behaviour:
- Reset while arstn_i=1:
  - gnt=0, rvalid=0, rdata=32'h0, err=0.
  - FSM goes to IDLE; latency counter is cleared.
  - RAM contents are not reset.
  - Reset mid-operation discards the pending response, so no rvalid is ever produced for it. A write already committed at its grant edge stays in memory.
- Word index = (data_addr_i - BASE_ADDR) >> 2, truncated to log2(RAM_WORDS) bits.
- In range means 0 <= data_addr_i - BASE_ADDR < RAM_WORDS*4, compared as unsigned 32-bit.
- FSM states: IDLE, BUSY.
- IDLE:
  - data_gnt_o = data_req_i (combinational).
  - On a grant edge: latch we, index and in-range flag.
  - Write: commit the enabled bytes at this same edge, and only if in range.
  - Read: sample the RAM word into a response register at this same edge, i.e. the data at acceptance time.
  - Load counter with RESP_LATENCY-1, then go to BUSY.
- BUSY:
  - gnt=0.
  - When the counter is nonzero, decrement it.
  - When the counter is 0, drive rvalid=1 for exactly this cycle:
    - rdata = sampled word for reads, 32'h0 for writes.
    - err as described under Optional Feature.
  - In that same rvalid cycle, gnt = data_req_i (back-to-back grant).
  - If granted: capture the new request as in IDLE and stay in BUSY with the counter reloaded.
  - If not granted: return to IDLE.
- Result: RESP_LATENCY=1 gives rvalid the cycle after the grant and sustains 1 transaction per cycle.
- Back-to-back hazard: a read granted in the rvalid cycle of a write to the same word returns the newly written data, because the write commits at the earlier grant edge.
- data_be_i=4'b0000 write: grant and respond normally; memory is unchanged.
- data_req_i dropping before a grant is legal: nothing is captured.
- Request signals are only sampled on the grant cycle.
- rdata/err hold their last response values while rvalid=0. Verification may check them only when rvalid=1.
- Outputs never X after reset.

Optional Feature:
- Macro: MIRISCV_DRAM_ERR_EN.
- Defined:
  - An out-of-range access is still granted and responded to at the normal latency.
  - Writes to out-of-range addresses are suppressed.
  - The read response is rdata=32'h0 with err=1 in the rvalid cycle.
  - In-range accesses give err=0.
- Undefined:
  - The range check is removed, so the index is the truncated offset and the address wraps modulo RAM_WORDS*4.
  - data_err_o is tied 0.

Test Plan:
- Reset, RESP_LATENCY=1: write 32'hDEADBEEF, be=4'hF, addr=BASE+0x10, then read the same address -> each gnt in its req cycle; rvalid 1 cycle after each gnt; read rdata=32'hDEADBEEF, err=0.
- Byte enables: over word 32'h11223344, write 32'hAABBCCDD with be=4'b0101, then read -> rdata=32'h11BB33DD; a be=0 write leaves it unchanged.
- RESP_LATENCY=3, req held high continuously, alternating reads -> gnt cycles are 3 apart, each rvalid exactly 3 cycles after its gnt, never two outstanding.
- RESP_LATENCY=1, write 32'h5 to A then read A back-to-back in the rvalid cycle -> second gnt in the first rvalid cycle; read returns 32'h5; one transaction per cycle sustained.
- Reset asserted one cycle after a read grant with RESP_LATENCY=4 -> rvalid never pulses; gnt=0 during reset; the next request after release is served normally.
- With MIRISCV_DRAM_ERR_EN, RAM_WORDS=1024: read BASE+0x1000 -> rvalid with err=1, rdata=0; a write there does not alter word 0. Without the macro, the same read returns word 0 with err=0.
